result_writeback: RTL

Downstream stage of the MAC-array top level. Gathers the N_MACS per-lane accumulator results, which arrive with skewed lane valids, into one output vector. Requantizes each lane to OUT_W bits and buffers completed vectors in a small FIFO. Writes them sequentially into the output BRAM, then signals frame completion to the controller.

---
 rtl/result_writeback_pkg.sv | 35 +++
 rtl/result_writeback_if.sv | 35 +++
 rtl/result_fifo.sv | 46 ++++
 rtl/result_writeback.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/result_writeback_pkg.sv
// Shared types and helpers for the MAC-array result stages: writeback FSM encoding and
// the shift-and-saturate requantizer.
package result_writeback_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } wb_state_e;

  // Arithmetic right shift, optional clamp of negatives to zero, then saturation to a signed
  // out_w-bit range. The result is returned sign-extended; callers keep the low out_w bits.
  function automatic logic signed [31:0] requant(input logic signed [63:0] acc,
                                                 input int unsigned      shift,
                                                 input int unsigned      out_w,
                                                 input bit               relu);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (relu && (t < 64'sd0)) begin
      t = 64'sd0;
    end
    if (t > hi) begin
      t = hi;
    end else if (t < lo) begin
      t = lo;
    end
    return t[31:0];
  endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Frame-control, lane-input and output-BRAM signals of the result writeback stage.
// master: the writeback stage itself; slave: the controller / MAC array / BRAM side.
interface result_writeback_if #(
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned N_MACS    = 4,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MEM_DEPTH = 256
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic                      start;
  logic [AW-1:0]             base_addr;
  logic [AW:0]               num_vectors;
  logic [N_MACS*ACC_W-1:0]   acc_in;
  logic [N_MACS-1:0]         valid_in;
  logic [AW-1:0]             out_bram_addr;
  logic                      out_bram_en;
  logic                      out_bram_we;
  logic [N_MACS*OUT_W-1:0]   out_bram_din;
  logic                      out_bram_rdy;
  logic                      busy;
  logic                      done;
  logic                      overflow;

  modport master (
    input  start, base_addr, num_vectors, acc_in, valid_in, out_bram_rdy,
    output out_bram_addr, out_bram_en, out_bram_we, out_bram_din, busy, done, overflow
  );

  modport slave (
    output start, base_addr, num_vectors, acc_in, valid_in, out_bram_rdy,
    input  out_bram_addr, out_bram_en, out_bram_we, out_bram_din, busy, done, overflow
  );

endinterface

// File: rtl/result_fifo.sv
// Small synchronous FIFO for completed output vectors; a pop frees a slot for a push in the
// same cycle, so push on a full FIFO succeeds when accompanied by a pop.
module result_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[PW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Gathers skewed per-lane accumulator results into vectors, requantizes, buffers and writes them
// to the output BRAM. Define RESULT_WRITEBACK_RELU_EN to clamp negative lanes to zero.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned N_MACS     = 4,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned SHIFT      = 4,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  result_writeback_if.master bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = N_MACS * OUT_W;

`ifdef RESULT_WRITEBACK_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  wb_state_e         state_q, state_d;
  logic [ACC_W-1:0]  lane_q [N_MACS];
  logic [ACC_W-1:0]  lane_d [N_MACS];
  logic [N_MACS-1:0] flag_q, flag_d, flag_set;
  logic              complete_q, complete_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     num_q, num_d, cap_q, cap_d, wr_q, wr_d;
  logic              ovf_q, ovf_d;

  logic [DW-1:0]     vec_data, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              run, active, push_vec, fifo_push, fifo_pop, drop, wr_active;

  assign run       = (state_q == StRun);
  assign active    = run || (state_q == StDrain);
  // complete_q marks the cycle after the last lane landed; lane_q still holds that vector.
  assign push_vec  = run && complete_q;
  assign wr_active = active && !fifo_empty;
  assign fifo_pop  = wr_active && bus.out_bram_rdy;
  assign fifo_push = push_vec && (!fifo_full || fifo_pop);
  assign drop      = push_vec && fifo_full && !fifo_pop;

  for (genvar g = 0; g < N_MACS; g++) begin : g_lane
    logic signed [31:0] q;
    logic               unused_q;
    assign q                             = requant(64'(signed'(lane_q[g])), SHIFT, OUT_W, Relu);
    assign vec_data[g*OUT_W +: OUT_W]    = q[OUT_W-1:0];
    assign unused_q                      = ^q[31:OUT_W];
  end

  result_fifo #(
    .Width (DW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (vec_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    flag_set   = flag_q;
    complete_d = 1'b0;
    wptr_d     = wptr_q;
    num_d      = num_q;
    ovf_d      = ovf_q;
    // Dropped vectors advance both counts so the frame still terminates.
    cap_d      = cap_q + CW'(push_vec);
    wr_d       = wr_q + CW'(fifo_pop) + CW'(drop);

    if (drop) begin
      ovf_d = 1'b1;
    end
    if (fifo_pop) begin
      wptr_d = (wptr_q == AW'(MEM_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end

    if (run) begin
      for (int i = 0; i < N_MACS; i++) begin
        if (bus.valid_in[i]) begin
          lane_d[i]   = bus.acc_in[i*ACC_W +: ACC_W];
          flag_set[i] = 1'b1;
          if (flag_q[i]) begin
            ovf_d = 1'b1;
          end
        end
      end
      complete_d = &flag_set;
    end
    flag_d = complete_d ? '0 : flag_set;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          wptr_d  = bus.base_addr;
          num_d   = bus.num_vectors;
          ovf_d   = 1'b0;
          cap_d   = '0;
          wr_d    = '0;
          flag_d  = '0;
          state_d = (bus.num_vectors == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (cap_d == num_q) state_d = StDrain;
      end
      StDrain: begin
        if (wr_d == num_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      lane_q     <= '{default: '0};
      flag_q     <= '0;
      complete_q <= 1'b0;
      wptr_q     <= '0;
      num_q      <= '0;
      cap_q      <= '0;
      wr_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      flag_q     <= flag_d;
      complete_q <= complete_d;
      wptr_q     <= wptr_d;
      num_q      <= num_d;
      cap_q      <= cap_d;
      wr_q       <= wr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.out_bram_en   = wr_active;
  assign bus.out_bram_we   = wr_active;
  assign bus.out_bram_addr = wr_active ? wptr_q : '0;
  assign bus.out_bram_din  = wr_active ? fifo_rdata : '0;
  assign bus.busy          = active;
  assign bus.done          = (state_q == StDone);
  assign bus.overflow      = ovf_q;

endmodule
